// File: rtl/pwm_pkg.sv
// Shared fixed-point helpers for the PWM output stages.
package pwm_pkg;

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic logic signed [31:0] fixed_one(input int frac_w);
    return 32'sd1 <<< frac_w;
  endfunction

  // Duty word width: one bit wider than the counter so 100 % is representable.
  function automatic int duty_w(input int cnt_w);
    return cnt_w + 1;
  endfunction

  // Symmetric clamp to [-lim, +lim]; operands are wide enough that nothing wraps.
  function automatic logic signed [31:0] clamp_s(input logic signed [31:0] x,
                                                 input logic signed [31:0] lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/deadtime_gen.sv
// Complementary gate-drive generator with dead-time insertion.
module deadtime_gen #(
  parameter int DEADTIME = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);

  localparam int RW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam logic [RW-1:0] DT = RW'(DEADTIME);

  logic          raw_q;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_c;
  logic          settled;

  // run restarts at 0 in the very cycle raw takes a new value.
  always_comb begin
    run_c   = (raw != raw_q) ? '0 : run_q;
    settled = (run_c >= DT);
  end

  // Age counter (saturating) and registered gate outputs; en low rearms dead-time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q  <= 1'b0;
      run_q  <= '0;
      pwm_hi <= 1'b0;
      pwm_lo <= 1'b0;
    end else begin
      raw_q  <= raw;
      if (!en)             run_q <= '0;
      else if (run_c < DT) run_q <= run_c + 1'b1;
      else                 run_q <= run_c;
      pwm_hi <= raw && settled;
      pwm_lo <= !raw && settled && en;
    end
  end

endmodule

// File: rtl/pwm_modulator.sv
// s(24,22) control value -> saturated duty -> dead-time protected PWM pair.
module pwm_modulator
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_WIDTH = 22,
  parameter int CNT_WIDTH  = 8,
  parameter int DEADTIME   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         ce_in,
  input  logic signed [DATA_WIDTH-1:0] sig_in,
  output logic                         ce_out,
  output logic                         pwm_hi,
  output logic                         pwm_lo,
  output logic                         sat
);

  localparam int                  DW       = duty_w(CNT_WIDTH);
  localparam int                  SHIFT    = FRAC_WIDTH + 1 - CNT_WIDTH;
  localparam logic signed [31:0]  ONE      = fixed_one(FRAC_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0]       DUTY_MID = {2'b01, {(CNT_WIDTH-1){1'b0}}};

  logic signed [31:0]   sx, xc, offs;
  logic [DW-1:0]        duty_nx;
  logic [DW-1:0]        shadow, duty_act;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 wrap;
  logic                 raw;

  // Clamp to +-1.0, then offset to 0..2.0 and scale down to 0..2^CNT_WIDTH.
  always_comb begin
    sx      = {{(32-DATA_WIDTH){sig_in[DATA_WIDTH-1]}}, sig_in};
    xc      = clamp_s(sx, ONE);
    offs    = xc + ONE;
    duty_nx = DW'(offs >>> SHIFT);
    wrap    = (cnt == CNT_MAX);
  end

  // Sample capture; the last ce_in before the wrap cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= DUTY_MID;
      sat    <= 1'b0;
    end else if (ce_in) begin
      shadow <= duty_nx;
      sat    <= (xc != sx);
    end
  end

  // Period counter, boundary-only duty update, raw compare and frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      duty_act <= DUTY_MID;
      raw      <= 1'b0;
      ce_out   <= 1'b0;
    end else begin
      cnt    <= en ? cnt + 1'b1 : '0;
      if (wrap) duty_act <= shadow;
      raw    <= en && ({1'b0, cnt} < duty_act);
      ce_out <= en && wrap;
    end
  end

  deadtime_gen #(.DEADTIME(DEADTIME)) u_dt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .raw    (raw),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo)
  );

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed bench for pwm_modulator with default parameters.
module tb_pwm_modulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               ce_in = 1'b0;
  logic signed [23:0] sig_in = '0;
  logic               ce_out, pwm_hi, pwm_lo, sat;

  int n_chk = 0;
  int n_err = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  pwm_modulator dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .ce_in  (ce_in),
    .sig_in (sig_in),
    .ce_out (ce_out),
    .pwm_hi (pwm_hi),
    .pwm_lo (pwm_lo),
    .sat    (sat)
  );

  // Shoot-through watch over the whole run.
  always @(negedge clk) if (rst_n && pwm_hi && pwm_lo) overlap++;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next negedge where ce_out is high (bounded).
  task automatic wait_ce(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ce_out) begin found = 1'b1; break; end
    end
    if (!found) chk({tag, "_ce_timeout"}, 0, 1);
  endtask

  // Count pwm_hi/pwm_lo/ce_out over one 256-clock frame starting now.
  task automatic measure(input string tag, input int ehi, input int elo);
    int h = 0, l = 0, c = 0;
    for (int k = 0; k < 256; k++) begin
      if (k > 0) @(negedge clk);
      h += int'(pwm_hi);
      l += int'(pwm_lo);
      c += int'(ce_out);
    end
    chk({tag, "_hi"}, h, ehi);
    chk({tag, "_lo"}, l, elo);
    chk({tag, "_ce"}, c, 1);
  endtask

  task automatic apply(input logic signed [23:0] v);
    sig_in = v;
    ce_in  = 1'b1;
    @(negedge clk);
    ce_in  = 1'b0;
  endtask

  // Load a value, skip the transition frame, measure a steady frame.
  task automatic steady(input string tag, input logic signed [23:0] v,
                        input int esat, input int ehi, input int elo);
    wait_ce(tag);
    apply(v);
    chk({tag, "_sat"}, int'(sat), esat);
    wait_ce(tag);
    wait_ce(tag);
    measure(tag, ehi, elo);
  endtask

  initial begin
    int n, h, l, c;
    repeat (3) @(negedge clk);
    chk("rst_hi", int'(pwm_hi), 0);
    chk("rst_lo", int'(pwm_lo), 0);
    chk("rst_ce", int'(ce_out), 0);
    chk("rst_sat", int'(sat), 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Reset duty 128: 124/124 with 4-clock gaps.
    wait_ce("d128");
    measure("d128", 124, 124);

    // 0.5 -> duty 192, effective from the next frame.
    wait_ce("d192");
    apply(24'sd2097152);
    chk("d192_sat", int'(sat), 0);
    wait_ce("d192");
    measure("d192", 188, 60);

    steady("p1_0", 24'sd4194304, 0, 256, 0);
    steady("m1_0", -24'sd4194304, 0, 0, 256);
    steady("p1_5", 24'sd6291456, 1, 256, 0);
    steady("m2_0", 24'h800000, 1, 0, 256);
    steady("p0_1", 24'sd419430, 0, 136, 112);
    steady("z0_0", 24'sd0, 0, 124, 124);

    // ce_in exactly on the cnt=255 cycle: one more frame at 128, then 192.
    wait_ce("wrap");
    repeat (255) @(negedge clk);
    sig_in = 24'sd2097152;
    ce_in  = 1'b1;
    @(negedge clk);
    ce_in  = 1'b0;
    measure("wrap_old", 124, 124);
    wait_ce("wrap_new");
    measure("wrap_new", 188, 60);

    // Asynchronous reset mid-period while pwm_hi is driving.
    wait_ce("rstm");
    repeat (100) @(negedge clk);
    chk("rstm_pre_hi", int'(pwm_hi), 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_hi", int'(pwm_hi), 0);
    chk("rstm_lo", int'(pwm_lo), 0);
    chk("rstm_ce", int'(ce_out), 0);
    chk("rstm_sat", int'(sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Cycle 1 after release holds cnt=0; cnt=255 is cycle 256; ce_out is cycle 257.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ce_out && n < 600);
    chk("rstm_first_ce", n, 256);
    measure("rstm_d128", 124, 124);

    // en low for 10 cycles: outputs quiet after the pipeline drains, no strobe.
    en = 1'b0;
    h = 0; l = 0; c = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      c += int'(ce_out);
      if (k >= 2) begin
        h += int'(pwm_hi);
        l += int'(pwm_lo);
      end
    end
    chk("en0_hi", h, 0);
    chk("en0_lo", l, 0);
    chk("en0_ce", c, 0);
    en = 1'b1;
    wait_ce("en1");
    measure("en1", 124, 124);

    chk("overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
